// File: rtl/clock_divide_pkg.sv
// clock_divide_pkg: shared types and defaults for the
// runtime-programmable clock divider controller.
package clock_divide_pkg;

  localparam int COUNT_WIDTH_DEF  = 8;
  localparam int DEFAULT_HALF_DEF = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: 2-way round-robin grant, pointer advances on grant.
// Ports: i_clock, i_reset_n, i_req[1:0], i_advance,
//        o_valid (any request), o_idx (winning requester).
module rr_arbiter2
  import clock_divide_pkg::*;
(
  input  logic       i_clock,
  input  logic       i_reset_n,
  input  logic [1:0] i_req,
  input  logic       i_advance,
  output logic       o_valid,
  output logic       o_idx
);

  logic r_ptr;

  assign o_valid = |i_req;

  always_comb begin
    o_idx = r_ptr;
    if (!i_req[r_ptr] && i_req[~r_ptr])
      o_idx = ~r_ptr;
  end

  // Favour the requester that did not just win.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n)
      r_ptr <= REQ0;
    else if (i_advance && o_valid)
      r_ptr <= ~o_idx;
  end

endmodule

// File: rtl/clock_divide_ctrl.sv
// clock_divide_ctrl: glitch-free programmable clock divider whose
// half-period is updated by two arbitrated requesters.
// Ports: i_clock, i_reset_n, i_enable, i_req[1:0],
//        i_half_count_0/1 (requested half-counts),
//        o_ack[1:0], o_clock, o_tick, o_running, o_busy,
//        o_active_half (half-count in use).
module clock_divide_ctrl
  import clock_divide_pkg::*;
#(
  parameter int COUNT_WIDTH  = COUNT_WIDTH_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic                   i_clock,
  input  logic                   i_reset_n,
  input  logic                   i_enable,
  input  logic [1:0]             i_req,
  input  logic [COUNT_WIDTH-1:0] i_half_count_0,
  input  logic [COUNT_WIDTH-1:0] i_half_count_1,
  output logic [1:0]             o_ack,
  output logic                   o_clock,
  output logic                   o_tick,
  output logic                   o_running,
  output logic                   o_busy,
  output logic [COUNT_WIDTH-1:0] o_active_half
);

  state_t                 r_state;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_active;
  logic [COUNT_WIDTH-1:0] r_pend;
  logic                   r_pend_idx;
  logic                   r_busy;
  logic                   r_clock;
  logic                   r_tick;
  logic                   r_running;
  logic [1:0]             r_ack;

  logic                   w_wrap;
  logic                   w_boundary;
  logic                   w_apply;
  logic                   w_grant_en;
  logic                   w_arb_valid;
  logic                   w_arb_idx;
  logic                   w_grant;
  logic [COUNT_WIDTH-1:0] w_hc_sel;

  assign w_wrap = (r_count == r_active);

  // Last low cycle before a rise: safe point to change ratio or stop.
  assign w_boundary = (r_state != ST_IDLE) && w_wrap && !r_clock;

  assign w_apply = r_busy &&
                   ((r_state == ST_IDLE) || w_boundary);

  // Block grants in the ack cycle: the acked requester still
  // holds i_req high during that cycle.
  assign w_grant_en = !r_busy && (r_ack == 2'b00);
  assign w_grant    = w_grant_en && w_arb_valid;

  assign w_hc_sel = (w_arb_idx == REQ1) ? i_half_count_1
                                        : i_half_count_0;

  rr_arbiter2 u_arb (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_req     (i_req),
    .i_advance (w_grant_en),
    .o_valid   (w_arb_valid),
    .o_idx     (w_arb_idx)
  );

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state    <= ST_IDLE;
      r_count    <= '0;
      r_active   <= COUNT_WIDTH'(DEFAULT_HALF);
      r_pend     <= '0;
      r_pend_idx <= REQ0;
      r_busy     <= 1'b0;
      r_clock    <= 1'b0;
      r_tick     <= 1'b0;
      r_running  <= 1'b0;
      r_ack      <= 2'b00;
    end else begin
      r_ack  <= 2'b00;
      r_tick <= 1'b0;

      if (w_apply) begin
        r_active          <= r_pend;
        r_ack[r_pend_idx] <= 1'b1;
        r_busy            <= 1'b0;
      end else if (w_grant) begin
        r_pend     <= w_hc_sel;
        r_pend_idx <= w_arb_idx;
        r_busy     <= 1'b1;
      end

      unique case (r_state)
        ST_IDLE: begin
          r_clock <= 1'b0;
          r_count <= '0;
          if (i_enable) begin
            r_state   <= ST_RUN;
            r_running <= 1'b1;
            r_clock   <= 1'b1;
            r_tick    <= 1'b1;
          end
        end
        ST_RUN, ST_STOPPING: begin
          if (!i_enable && w_boundary) begin
            r_state   <= ST_IDLE;
            r_running <= 1'b0;
            r_count   <= '0;
            r_clock   <= 1'b0;
          end else begin
            r_state <= i_enable ? ST_RUN : ST_STOPPING;
            if (w_wrap) begin
              r_count <= '0;
              r_clock <= ~r_clock;
              r_tick  <= ~r_clock;
            end else begin
              r_count <= r_count + 1'b1;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_running <= 1'b0;
          r_count   <= '0;
          r_clock   <= 1'b0;
        end
      endcase
    end
  end

  assign o_ack         = r_ack;
  assign o_clock       = r_clock;
  assign o_tick        = r_tick;
  assign o_running     = r_running;
  assign o_busy        = r_busy;
  assign o_active_half = r_active;

endmodule

// File: tb/tb_clock_divide_ctrl.sv
// tb_clock_divide_ctrl: directed bench for clock_divide_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_clock_divide_ctrl;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [1:0] req;
  logic [7:0] hc0;
  logic [7:0] hc1;
  logic [1:0] ack;
  logic       oclk;
  logic       tick;
  logic       running;
  logic       busy;
  logic [7:0] act;

  int checks;
  int failures;

  clock_divide_ctrl dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_enable       (en),
    .i_req          (req),
    .i_half_count_0 (hc0),
    .i_half_count_1 (hc1),
    .o_ack          (ack),
    .o_clock        (oclk),
    .o_tick         (tick),
    .o_running      (running),
    .o_busy         (busy),
    .o_active_half  (act)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic cap(input int n,
                     output logic [31:0] vc,
                     output logic [31:0] vt,
                     output logic [31:0] vk,
                     output logic [31:0] vb,
                     output logic [31:0] vr);
    vc = '0; vt = '0; vk = '0; vb = '0; vr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      vc[i] = oclk;
      vt[i] = tick;
      vk[i] = |ack;
      vb[i] = busy;
      vr[i] = running;
    end
  endtask

  task automatic wait_ack(input int idx, input int lim,
                          output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ack[idx] && n < lim);
  endtask

  task automatic wait_tick(input int lim);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < lim);
    chk("tick_wait", 32'(tick), 32'd1);
  endtask

  logic [31:0] vc, vt, vk, vb, vr;
  int n;
  int acks_seen;

  initial begin
    checks   = 0;
    failures = 0;
    hc0 = 8'd0;
    hc1 = 8'd0;

    // reset values, then free run at h=4
    do_reset();
    chk("rst_clk",  32'(oclk),    32'd0);
    chk("rst_tick", 32'(tick),    32'd0);
    chk("rst_run",  32'(running), 32'd0);
    chk("rst_busy", 32'(busy),    32'd0);
    chk("rst_ack",  32'(ack),     32'd0);
    chk("rst_act",  32'(act),     32'd4);
    en = 1'b1;
    cap(20, vc, vt, vk, vb, vr);
    chk("h4_clk",  vc, 32'h0007C1F);
    chk("h4_tick", vt, 32'h0000401);
    chk("h4_run",  vr, 32'h00FFFFF);

    // req0 -> h=1 issued mid-high, dropped before ack
    wait_tick(30);
    repeat (2) @(negedge clk);
    hc0 = 8'd1;
    req = 2'b01;
    @(negedge clk);
    chk("upd_busy", 32'(busy), 32'd1);
    req = 2'b00;
    cap(15, vc, vt, vk, vb, vr);
    chk("upd_clk",  vc, 32'(15'b100110011000001));
    chk("upd_tick", vt, 32'(15'b100010001000000));
    chk("upd_ack",  vk, 32'(15'b000000001000000));
    chk("upd_busy_v", vb, 32'(15'b000000000111111));
    chk("upd_act", 32'(act), 32'd1);

    // simultaneous requests from reset while starting
    do_reset();
    hc0 = 8'd2;
    hc1 = 8'd7;
    req = 2'b11;
    en  = 1'b1;
    wait_ack(0, 40, n);
    chk("ack0_lat", 32'(n),   32'd11);
    chk("ack0_vec", 32'(ack), 32'd1);
    chk("act_2",    32'(act), 32'd2);
    req[0] = 1'b0;
    @(negedge clk);
    chk("no_grant_ack", 32'(busy), 32'd0);
    wait_ack(1, 40, n);
    chk("ack1_lat", 32'(n),   32'd5);
    chk("act_7",    32'(act), 32'd7);
    req[1] = 1'b0;
    @(negedge clk);
    chk("ack_clear",  32'(ack),  32'd0);
    chk("no_regrant", 32'(busy), 32'd0);

    // stop requested in the high phase
    do_reset();
    en = 1'b1;
    repeat (3) @(negedge clk);
    chk("stop_pre", 32'(oclk), 32'd1);
    en = 1'b0;
    cap(12, vc, vt, vk, vb, vr);
    chk("stop_clk",  vc, 32'h003);
    chk("stop_run",  vr, 32'h07F);
    chk("stop_tick", vt, 32'h000);

    // h=0 from req1 while idle, then divide-by-2
    hc1 = 8'd0;
    req = 2'b10;
    wait_ack(1, 10, n);
    chk("idle_ack_lat", 32'(n),   32'd2);
    chk("idle_act0",    32'(act), 32'd0);
    req = 2'b00;
    en  = 1'b1;
    cap(8, vc, vt, vk, vb, vr);
    chk("div2_clk",  vc, 32'h55);
    chk("div2_tick", vt, 32'h55);

    // async reset with an update pending
    do_reset();
    en = 1'b1;
    repeat (2) @(negedge clk);
    hc0 = 8'd9;
    req = 2'b01;
    @(negedge clk);
    chk("pend_busy", 32'(busy), 32'd1);
    chk("pend_clk",  32'(oclk), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_clk",  32'(oclk),    32'd0);
    chk("arst_busy", 32'(busy),    32'd0);
    chk("arst_act",  32'(act),     32'd4);
    chk("arst_run",  32'(running), 32'd0);
    req = 2'b00;
    en  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    acks_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (|ack) acks_seen++;
    end
    chk("arst_no_ack", 32'(acks_seen), 32'd0);
    chk("arst_act_hold", 32'(act), 32'd4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_divide_ctrl.md
Name: clock_divide_ctrl

Overview:
Runtime-programmable clock divider controller that shares the divide ratio between two requesters. A 2-way round-robin arbiter picks one requester's new half-period value. The new value is applied only at a full output-period boundary, so o_clock never glitches. Start and stop are also aligned to period boundaries. The block sits between software/config agents and any logic that consumes o_clock or the o_tick enable.

Parameters:
COUNT_WIDTH, 8, width of half-period counter and ratio inputs
DEFAULT_HALF, 4, active half-count after reset (100 MHz in -> 10 MHz out)

Ports:
i_clock  in  1  system clock, single clock domain
i_reset_n  in  1  asynchronous, active-low reset
i_enable  in  1  level; 1 = run divider, 0 = stop at next period boundary
i_req  in  2  per-requester ratio-change request; held high until matching o_ack
i_half_count_0  in  COUNT_WIDTH  requested half-count, requester 0
i_half_count_1  in  COUNT_WIDTH  requested half-count, requester 1
o_ack  out  2  one-cycle pulse when that requester's value becomes active
o_clock  out  1  divided clock, driven directly from a flop
o_tick  out  1  one-cycle pulse coincident with each o_clock rise
o_running  out  1  1 in RUN or STOPPING
o_busy  out  1  a captured update is pending
o_active_half  out  COUNT_WIDTH  half-count currently in use

Behaviour:
- Half-period = h+1 input cycles; output period = 2(h+1); f_out = f_clk/(2(h+1)); h=0 gives divide-by-2.
- Reset (asynchronous, mid-operation included) sets: state IDLE, o_clock=0, o_tick=0, count=0, o_ack=0, o_busy=0, o_running=0, o_active_half=DEFAULT_HALF, arbiter pointer favours requester 0. Any pending update is discarded.
- FSM states: IDLE, RUN, STOPPING.
- IDLE:
  - o_clock=0.
  - If i_enable=1 is sampled, the next edge moves to RUN with o_clock=1, o_tick=1, count=0. Latency from enable to first rise is 1 cycle.
- RUN:
  - count increments each cycle.
  - When count==active_half: count<=0 and o_clock<=~o_clock.
  - o_tick=1 only on edges where o_clock goes 0->1.
- Period boundary: the cycle where count==active_half and o_clock==0, i.e. the final low cycle before a rise.
- STOPPING:
  - Entered from RUN when i_enable=0.
  - Counting continues until the next period boundary. At that boundary, go to IDLE with o_clock held 0 and no tick.
  - If i_enable returns to 1 while in STOPPING, go back to RUN with no disturbance to count or o_clock.
- Arbitration and capture:
  - When o_busy=0 and any i_req bit is set, grant one request per round-robin.
  - On grant, capture that requester's i_half_count_n and its index, and set o_busy=1.
  - The pointer moves to the other requester after each grant.
- Apply:
  - RUN/STOPPING: at the period boundary, active_half<=captured value, o_ack[idx] pulses, o_busy clears. The next high phase uses the new value.
  - IDLE: the update applies on the cycle after capture.
- Requester protocol:
  - Deassert i_req the cycle after o_ack. A request still high after that cycle counts as a new request.
  - A request dropped before its ack is still applied.
- Simultaneous events:
  - No new grant in the cycle o_busy clears; the earliest next grant is the following cycle.
  - If apply and stop coincide at a boundary, apply first, then IDLE; o_active_half is updated.
  - Both i_req bits set: the pointer holder wins and the other waits.
- Width: count and ratio are unsigned COUNT_WIDTH; no saturation is needed because count never exceeds active_half.

Decomposition:
- Package clock_divide_pkg holds:
  - the state enum (IDLE, RUN, STOPPING);
  - COUNT_WIDTH and DEFAULT_HALF defaults;
  - requester-index constants.
- Sub-module rr_arbiter2: 2-way round-robin grant with advance-on-grant input.

Test Plan:
- Reset, then i_enable=1 with h=4 -> first rise 1 cycle later; o_clock 5 cycles high, 5 low, repeating; o_tick every 10 cycles.
- RUN with h=4; req0 with value 1 asserted mid-high phase -> o_busy=1 next cycle; o_ack[0] at the period boundary; following periods are 4 cycles (2 high, 2 low); no short pulse.
- req0 (h=2) and req1 (h=7) together after reset -> req0 acked at the first boundary, req1 granted the next cycle and acked at the next boundary; o_active_half goes 2 then 7.
- i_enable dropped at cycle 2 of the high phase (h=4) -> high completes 5 cycles and low 5 cycles, then IDLE; o_running=0 and o_clock stays 0.
- h=0 from req1 while IDLE -> o_ack[1] 2 cycles after req; on enable, o_clock toggles every cycle and o_tick fires every 2 cycles.
- i_reset_n asserted mid-high phase with an update pending -> o_clock=0 immediately; o_busy=0; o_active_half=4; no o_ack is ever issued for the discarded update.
